// File: rtl/instruction_fetch_unit.sv
// Purpose: instruction fetch: PC register, IMEM request/response, stall hold and redirect discard.
// Latency: zero cycles from IMemReady to InstructionOut; one instruction per cycle while IMemReady stays high.
// Backpressure: Stall_ID parks the fetched word in S_HOLD; optional perf counters when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCSel,
    input  logic [31:0] BranchTarget,
    input  logic        Stall_ID,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCPlusFourOut,
    output logic        FetchValid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] StallCycles,
    output logic [31:0] BubbleCycles,
`endif
    output logic [31:0] PCOut
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    // Address of the request still in flight when a redirect arrived mid-request
    logic [31:0] stale_addr_q, stale_addr_d;

    logic        redirect;
    logic [31:0] pc_plus4;

    // A redirect while decode is stalled belongs to a stalled instruction and is ignored
    assign redirect = PCSel & ~Stall_ID;
    assign pc_plus4 = pc_q + 32'd4;
    assign PCOut    = pc_q;

    // Next-state and output decode; reset forces the bubble outputs last
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_instr_d   = hold_instr_q;
        hold_pc4_d     = hold_pc4_q;
        stale_addr_d   = stale_addr_q;
        IMemReq        = 1'b0;
        IMemAddr       = pc_q;
        FetchValid     = 1'b0;
        InstructionOut = 32'h0;
        PCPlusFourOut  = 32'h0;

        case (state_q)
            S_REQ: begin
                IMemReq = 1'b1;
                if (IMemReady) begin
                    if (redirect) begin
                        // Fetched word is on the wrong path: drop it
                        pc_d = BranchTarget;
                    end else begin
                        FetchValid     = 1'b1;
                        InstructionOut = IMemData;
                        PCPlusFourOut  = pc_plus4;
                        if (Stall_ID) begin
                            hold_instr_d = IMemData;
                            hold_pc4_d   = pc_plus4;
                            state_d      = S_HOLD;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end else if (redirect) begin
                    // Memory still owes a response for the old address; keep asking for it
                    pc_d         = BranchTarget;
                    stale_addr_d = pc_q;
                    state_d      = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = BranchTarget;
                    state_d = S_REQ;
                end else begin
                    FetchValid     = 1'b1;
                    InstructionOut = hold_instr_q;
                    PCPlusFourOut  = hold_pc4_q;
                    if (!Stall_ID) begin
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end
                end
            end
            S_DISCARD: begin
                IMemReq  = 1'b1;
                IMemAddr = stale_addr_q;
                if (redirect) begin
                    pc_d = BranchTarget;
                end
                if (IMemReady) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (Reset) begin
            IMemReq        = 1'b0;
            FetchValid     = 1'b0;
            InstructionOut = 32'h0;
            PCPlusFourOut  = 32'h0;
        end
    end

    // State, PC and hold registers; reset overrides every other input
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
            stale_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            stale_addr_q <= stale_addr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating counters of hold cycles and of cycles without a valid fetch
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (state_q == S_HOLD && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!FetchValid && bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign StallCycles  = stall_cnt_q;
    assign BubbleCycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose: directed, table-driven check of instruction_fetch_unit plus a wrap-around sequence.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: stall, redirect-while-stalled and discard scenarios are in the vector table.
module tb_instruction_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        PCSel;
    logic [31:0] BranchTarget;
    logic        Stall_ID;
    logic        IMemReady;
    logic [31:0] IMemData;

    logic        req1, fv1;
    logic [31:0] addr1, ins1, pc4_1, pco1;
    logic        req2, fv2;
    logic [31:0] addr2, ins2, pc4_2, pco2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stc1, bbc1, stc2, bbc2;
`endif

    instruction_fetch_unit dut (
        .Clock(Clock), .Reset(Reset), .PCSel(PCSel), .BranchTarget(BranchTarget),
        .Stall_ID(Stall_ID), .IMemReq(req1), .IMemAddr(addr1), .IMemReady(IMemReady),
        .IMemData(IMemData), .InstructionOut(ins1), .PCPlusFourOut(pc4_1),
        .FetchValid(fv1),
`ifdef FETCH_PERF_CNT_EN
        .StallCycles(stc1), .BubbleCycles(bbc1),
`endif
        .PCOut(pco1)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clock(Clock), .Reset(Reset), .PCSel(PCSel), .BranchTarget(BranchTarget),
        .Stall_ID(Stall_ID), .IMemReq(req2), .IMemAddr(addr2), .IMemReady(IMemReady),
        .IMemData(IMemData), .InstructionOut(ins2), .PCPlusFourOut(pc4_2),
        .FetchValid(fv2),
`ifdef FETCH_PERF_CNT_EN
        .StallCycles(stc2), .BubbleCycles(bbc2),
`endif
        .PCOut(pco2)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        rst;
        logic        sel;
        logic [31:0] bt;
        logic        stl;
        logic        rdy;
        logic [31:0] dat;
        logic        ck_pc;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic [31:0] pco;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic rst, logic sel, logic [31:0] bt, logic stl, logic rdy,
                                logic [31:0] dat, logic ck_pc, logic req, logic [31:0] addr,
                                logic fv, logic [31:0] ins, logic [31:0] pc4, logic [31:0] pco);
        vec_t v;
        v.rst = rst; v.sel = sel; v.bt = bt; v.stl = stl; v.rdy = rdy; v.dat = dat;
        v.ck_pc = ck_pc; v.req = req; v.addr = addr; v.fv = fv; v.ins = ins;
        v.pc4 = pc4; v.pco = pco;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; PCSel = 1'b0; BranchTarget = 32'h0; Stall_ID = 1'b0;
        IMemReady = 1'b0; IMemData = 32'h0;

        //                rst sel bt          stl rdy dat           ck req addr        fv ins           pc4         pco
        // Reset: outputs quiet, IMemReady ignored
        vecs.push_back(mk(1, 0, 32'h0,       0, 1, 32'hDEADBEEF, 0, 0, 32'h0,       0, 32'h0,        32'h0,      32'h0));
        vecs.push_back(mk(1, 0, 32'h0,       0, 1, 32'hDEADBEEF, 1, 0, 32'h0,       0, 32'h0,        32'h0,      32'h0));
        // Back-to-back fetch 0,4,8,12
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h11110000, 1, 1, 32'h0,       1, 32'h11110000, 32'h4,      32'h0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h11110004, 1, 1, 32'h4,       1, 32'h11110004, 32'h8,      32'h4));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h11110008, 1, 1, 32'h8,       1, 32'h11110008, 32'hC,      32'h8));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h1111000C, 1, 1, 32'hC,       1, 32'h1111000C, 32'h10,     32'hC));
        // Memory not ready: address held, bubble
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 1, 32'h10,      0, 32'h0,        32'h0,      32'h10));
        // Stall three cycles: word captured, held, request dropped
        vecs.push_back(mk(0, 0, 32'h0,       1, 1, 32'h8C020004, 1, 1, 32'h10,      1, 32'h8C020004, 32'h14,     32'h10));
        vecs.push_back(mk(0, 0, 32'h0,       1, 1, 32'hFFFFFFFF, 1, 0, 32'h10,      1, 32'h8C020004, 32'h14,     32'h10));
        vecs.push_back(mk(0, 0, 32'h0,       1, 0, 32'h0,        1, 0, 32'h10,      1, 32'h8C020004, 32'h14,     32'h10));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 0, 32'h10,      1, 32'h8C020004, 32'h14,     32'h10));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 1, 32'h14,      0, 32'h0,        32'h0,      32'h14));
        // Redirect with no response yet: discard the stale reply, then fetch 0x40
        vecs.push_back(mk(0, 1, 32'h40,      0, 0, 32'h0,        1, 1, 32'h14,      0, 32'h0,        32'h0,      32'h14));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 1, 32'h14,      0, 32'h0,        32'h0,      32'h40));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h22220014, 1, 1, 32'h14,      0, 32'h0,        32'h0,      32'h40));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h22220040, 1, 1, 32'h40,      1, 32'h22220040, 32'h44,     32'h40));
        // PCSel during stall ignored; taken on first unstalled cycle
        vecs.push_back(mk(0, 1, 32'h100,     1, 1, 32'h33330044, 1, 1, 32'h44,      1, 32'h33330044, 32'h48,     32'h44));
        vecs.push_back(mk(0, 1, 32'h100,     1, 0, 32'h0,        1, 0, 32'h44,      1, 32'h33330044, 32'h48,     32'h44));
        vecs.push_back(mk(0, 1, 32'h100,     0, 0, 32'h0,        1, 0, 32'h44,      0, 32'h0,        32'h0,      32'h44));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h44440100, 1, 1, 32'h100,     1, 32'h44440100, 32'h104,    32'h100));
        // Redirect coinciding with a response: word dropped
        vecs.push_back(mk(0, 1, 32'h200,     0, 1, 32'h55550104, 1, 1, 32'h104,     0, 32'h0,        32'h0,      32'h104));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h55550200, 1, 1, 32'h200,     1, 32'h55550200, 32'h204,    32'h200));
        // Second redirect while discarding wins
        vecs.push_back(mk(0, 1, 32'h300,     0, 0, 32'h0,        1, 1, 32'h204,     0, 32'h0,        32'h0,      32'h204));
        vecs.push_back(mk(0, 1, 32'h400,     0, 0, 32'h0,        1, 1, 32'h204,     0, 32'h0,        32'h0,      32'h300));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'hABABABAB, 1, 1, 32'h204,     0, 32'h0,        32'h0,      32'h400));
        vecs.push_back(mk(0, 0, 32'h0,       0, 1, 32'h66660400, 1, 1, 32'h400,     1, 32'h66660400, 32'h404,    32'h400));
        // Reset while discarding
        vecs.push_back(mk(0, 1, 32'h500,     0, 0, 32'h0,        1, 1, 32'h404,     0, 32'h0,        32'h0,      32'h404));
        vecs.push_back(mk(1, 0, 32'h0,       0, 1, 32'h77777777, 1, 0, 32'h404,     0, 32'h0,        32'h0,      32'h500));
        vecs.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 1, 32'h0,       0, 32'h0,        32'h0,      32'h0));

        foreach (vecs[i]) begin
            @(negedge Clock);
            Reset = vecs[i].rst; PCSel = vecs[i].sel; BranchTarget = vecs[i].bt;
            Stall_ID = vecs[i].stl; IMemReady = vecs[i].rdy; IMemData = vecs[i].dat;
            #1;
            chk("IMemReq", i, {31'h0, req1}, {31'h0, vecs[i].req});
            chk("FetchValid", i, {31'h0, fv1}, {31'h0, vecs[i].fv});
            chk("InstructionOut", i, ins1, vecs[i].ins);
            chk("PCPlusFourOut", i, pc4_1, vecs[i].pc4);
            if (vecs[i].ck_pc) begin
                chk("IMemAddr", i, addr1, vecs[i].addr);
                chk("PCOut", i, pco1, vecs[i].pco);
            end
        end

        // Wrap-around from RESET_PC = 0xFFFFFFFC
        @(negedge Clock);
        Reset = 1'b1; PCSel = 1'b0; Stall_ID = 1'b0; IMemReady = 1'b1; IMemData = 32'h99990000;
        #1;
        chk("wrap_req_in_reset", 100, {31'h0, req2}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0; IMemData = 32'h9999FFFC;
        #1;
        chk("wrap_addr0", 101, addr2, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", 101, pc4_2, 32'h0);
        chk("wrap_ins0", 101, ins2, 32'h9999FFFC);
        chk("wrap_fv0", 101, {31'h0, fv2}, 32'h1);
        @(negedge Clock);
        IMemData = 32'h99990000;
        #1;
        chk("wrap_addr1", 102, addr2, 32'h0);
        chk("wrap_pc4_1", 102, pc4_2, 32'h4);
        chk("wrap_pco1", 102, pco2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, holding the PC value loaded on reset.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port PCSel, input, 1 bit: redirect request from decode.
REQ-005 SHALL have port BranchTarget, input, 32 bits: redirect address, valid when PCSel=1.
REQ-006 SHALL have port Stall_ID, input, 1 bit: decode stalled; the fetched instruction must be held.
REQ-007 SHALL have port IMemReq, output, 1 bit: instruction memory request.
REQ-008 SHALL have port IMemAddr, output, 32 bits: request address.
REQ-009 SHALL have port IMemReady, input, 1 bit: memory response valid this cycle.
REQ-010 SHALL have port IMemData, input, 32 bits: instruction word, valid when IMemReady=1.
REQ-011 SHALL have port InstructionOut, output, 32 bits: instruction to the IF/ID register.
REQ-012 SHALL have port PCPlusFourOut, output, 32 bits: address of the presented instruction plus 4.
REQ-013 SHALL have port FetchValid, output, 1 bit: InstructionOut carries a real instruction.
REQ-014 SHALL have port PCOut, output, 32 bits: current PC register.

Function
REQ-015 SHALL implement FSM states S_REQ (request outstanding), S_HOLD (instruction held for stalled decode) and S_DISCARD (stale request in flight after a redirect).
REQ-016 SHALL treat a redirect as effective only when PCSel=1 and Stall_ID=0; PCSel with Stall_ID=1 SHALL be ignored.
REQ-017 In S_REQ, SHALL assert IMemReq=1 with IMemAddr=PC, and hold the address stable until IMemReady=1.
REQ-018 In S_REQ with IMemReady=1, no redirect and Stall_ID=0, SHALL present IMemData combinationally with FetchValid=1, PCPlusFourOut=PC+4, and update PC<=PC+4 on the edge, staying in S_REQ.
REQ-019 In S_REQ with IMemReady=1 and Stall_ID=1, SHALL capture IMemData and PC+4 into hold registers and enter S_HOLD.
REQ-020 In S_HOLD, SHALL drive IMemReq=0 and present the held instruction with FetchValid=1; when Stall_ID=0 with no redirect, SHALL update PC<=PC+4 and enter S_REQ.
REQ-021 On an effective redirect in S_REQ with IMemReady=1, or in S_HOLD, SHALL update PC<=BranchTarget, drop the instruction (FetchValid=0) and enter S_REQ.
REQ-022 On an effective redirect in S_REQ with IMemReady=0, SHALL update PC<=BranchTarget, retain the stale address on IMemAddr with IMemReq=1, and enter S_DISCARD.
REQ-023 In S_DISCARD, SHALL update PC<=BranchTarget on any further effective redirect; on IMemReady=1, SHALL drop the response and enter S_REQ.
REQ-024 Whenever FetchValid=0, SHALL drive InstructionOut=0 and PCPlusFourOut=0 (nop bubble).
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; PC 32'hFFFFFFFC SHALL wrap to 0.
REQ-026 Latency SHALL be zero cycles from IMemReady to InstructionOut; back-to-back requests SHALL be possible (one instruction per cycle when IMemReady is held at 1).

Reset
REQ-027 When Reset=1 at a posedge, SHALL set PC=RESET_PC, state=S_REQ and clear the hold registers, overriding all other inputs, including mid-request and in S_DISCARD.
REQ-028 While Reset=1, SHALL drive IMemReq=0, FetchValid=0, InstructionOut=0 and PCPlusFourOut=0, and ignore IMemReady.

Configuration
REQ-029 With macro FETCH_PERF_CNT_EN defined, SHALL add 32-bit outputs StallCycles (counting cycles in S_HOLD) and BubbleCycles (counting cycles with FetchValid=0, Reset=0), both saturating at 32'hFFFFFFFF and cleared by Reset.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then IMemReady=1 constantly -> IMemAddr sequence 0,4,8,12; PCPlusFourOut 4,8,12,16; FetchValid=1 each cycle.
REQ-032 Stall_ID=1 for 3 cycles with IMemData=32'h8C020004 -> S_HOLD; IMemReq=0; InstructionOut held at 32'h8C020004; PC advances by 4 only after release.
REQ-033 PCSel=1 with BranchTarget=32'h40 while IMemReady=0 -> S_DISCARD; the next response is dropped (FetchValid=0, InstructionOut=0); the following IMemAddr is 32'h40.
REQ-034 PCSel=1 with Stall_ID=1 -> no redirect; PC unchanged; redirect taken in the first cycle after Stall_ID=0.
REQ-035 RESET_PC=32'hFFFFFFFC with IMemReady=1 -> the next IMemAddr is 0; Reset asserted in S_DISCARD -> IMemReq=0 and PC=RESET_PC the next cycle.
